nios2_busout_arbiter: RTL
=========================

// Module: nios2_busout_arbiter
// PURPOSE
//  Round-robin write arbiter sharing one 8-bit Avalon-MM output PIO (s1, data reg at address 0) among NREQ game-logic requesters.
//  Masters the PIO slave port directly and enforces a minimum hold time per written byte.
//  Optionally reads each byte back from the PIO and flags mismatches.
//  Sits between the game FSMs and the Nios II bus-output PIO.
// PARAMETERS
//  NREQ        4   number of requesters, 2..8
//  HOLD_CYCLES 16  clk cycles out_port is held after each write before the next grant; 0 = no hold
// PORTS
//  clk            in   1        system clock
//  reset_n        in   1        asynchronous, active-low reset
//  req            in   NREQ     per-requester write request, level
//  req_data       in   8*NREQ   byte for requester i at [8*i+7:8*i]
//  gnt            out  NREQ     one-cycle pulse: requester's byte is being written
//  busy           out  1        high in any state other than IDLE
//  pio_address    out  2        PIO address; always 0
//  pio_chipselect out  1        PIO chipselect
//  pio_write_n    out  1        PIO write strobe, active-low
//  pio_writedata  out  32       {24'b0, byte}
//  pio_readdata   in   32       PIO readdata, combinational in the PIO
//  err            out  1        sticky readback mismatch; 0 when BUSOUT_READBACK_EN is undefined
//  err_clr        in   1        clears err
// BEHAVIOUR
//  - Reset values: state=IDLE, gnt=0, busy=0, pio_chipselect=0, pio_write_n=1, pio_writedata=0, err=0, last=NREQ-1.
//    Requester 0 has top priority after reset.
//  - FSM states: IDLE -> WRITE -> [READ] -> HOLD -> IDLE.
//  - IDLE: at a clk edge with |req, pick the first set req bit searching from last+1 with modulo-NREQ wrap.
//    Register winner index and its byte; last<=winner; go to WRITE.
//  - WRITE, exactly 1 cycle: pio_chipselect=1, pio_write_n=0, pio_writedata={24'b0,byte}, gnt[winner]=1.
//    Next state is READ if the macro is defined, else HOLD, or IDLE when HOLD_CYCLES==0.
//  - Latency: req sampled high at edge N means the write strobe is in cycle N+1.
//  - Write-to-write spacing = HOLD_CYCLES+2 cycles, +1 with readback.
//  - HOLD: a down-counter of width $clog2(HOLD_CYCLES+1) runs for exactly HOLD_CYCLES cycles with no strobes, then IDLE.
//  - Requester rule: hold req and req_data stable until gnt.
//    Data is captured at the arbitration edge; a later change or drop of req does not abort the write, and gnt still pulses.
//    A requester that keeps req high after gnt gets another grant only after the others are served (round-robin fairness).
//  - Simultaneous requests: strict rotation. All NREQ high continuously gives grants 0,1,2,3,0,...
//  - Single requester continuously high: granted every spacing period.
//  - Async reset mid-operation: immediate return to reset values.
//    An in-flight strobe is dropped; the PIO register keeps whatever it last latched.
// CONFIGURATION
//  - BUSOUT_READBACK_EN defined:
//    - READ state, 1 cycle after WRITE: pio_chipselect=1, pio_write_n=1, address 0.
//    - At its closing edge, pio_readdata[7:0] is compared with the written byte; mismatch sets err.
//    - pio_readdata[31:8] is ignored.
//    - err_clr clears err; a set in the same cycle wins over the clear.
//  - BUSOUT_READBACK_EN undefined: no READ state; err tied 0; pio_readdata and err_clr unused.
// TESTING
//  1. Reset with req=0: all outputs at reset values, busy=0, pio_write_n=1 for 100 cycles.
//  2. req=4'b0001, data0=8'hA5, HOLD_CYCLES=16: strobe with writedata=32'h000000A5 one cycle after req.
//     gnt[0] pulses in the strobe cycle; next strobe 18 cycles later (19 with readback).
//  3. req=4'b1111, data bytes 8'h10/8'h21/8'h32/8'h43 held: write sequence 10,21,32,43,10.
//     Each gnt pulses once per rotation.
//  4. Grant to 2, then req=4'b0101: next grant goes to 0 (search from 3 wraps), then 2.
//  5. Assert reset_n=0 in HOLD cycle 5, release after 3 cycles: outputs at reset values.
//     With req=4'b1001 the next grant is 0.
//  6. BUSOUT_READBACK_EN defined, model PIO returns 8'h00 on write 8'h5A: err=1 after READ and stays 1.
//     Pulsing err_clr clears it; a good write keeps err=0.

Source files
------------

// File: rtl/nios2_busout_arbiter.sv
// nios2_busout_arbiter
// Round-robin write arbiter that lets NREQ game-logic requesters share one
// 8-bit Avalon-MM output PIO (data register at address 0). Each written byte
// is held on the PIO for at least HOLD_CYCLES cycles before the next grant.
//
// Optional feature: define BUSOUT_READBACK_EN to add a READ cycle after each
// write that reads the byte back and sets a sticky err flag on mismatch.
//
// Handshake: a requester raises req[i] with req_data[8*i+7:8*i] and holds both
// stable until gnt[i] pulses. Data is captured at the arbitration edge, so a
// later change or drop of req does not abort the write already chosen.
//
// state_dbg exposes the FSM state: 0=IDLE 1=WRITE 2=READ 3=HOLD.
module nios2_busout_arbiter #(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     gnt,
  output logic                busy,
  output logic [1:0]          pio_address,
  output logic                pio_chipselect,
  output logic                pio_write_n,
  output logic [31:0]         pio_writedata,
  input  logic [31:0]         pio_readdata,
  output logic                err,
  input  logic                err_clr,
  output logic [1:0]          state_dbg
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t          state;
  logic [IW-1:0]   last;
  logic [IW-1:0]   win_idx;
  logic            win_found;
  logic [CW-1:0]   hold_cnt;

  assign pio_address = 2'b00;
  assign busy        = (state != S_IDLE);
  assign state_dbg   = state;

  // Round-robin pick: first set req bit searching upward from last+1, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last;
    for (int k = 1; k <= NREQ; k++) begin
      if (!win_found && req[(int'(last) + k) % NREQ]) begin
        win_found = 1'b1;
        win_idx   = IW'((int'(last) + k) % NREQ);
      end
    end
  end

  // Main FSM: arbitration, write strobe, optional readback, hold timer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      last           <= IW'(NREQ - 1);
      gnt            <= '0;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_writedata  <= 32'd0;
      hold_cnt       <= '0;
    end else begin
      gnt <= '0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            state          <= S_WRITE;
            last           <= win_idx;
            gnt            <= NREQ'(1) << win_idx;
            pio_chipselect <= 1'b1;
            pio_write_n    <= 1'b0;
            pio_writedata  <= {24'd0, req_data[int'(win_idx)*8 +: 8]};
          end
        end
        S_WRITE: begin
          pio_write_n <= 1'b1;
`ifdef BUSOUT_READBACK_EN
          // Keep chipselect up for the readback cycle.
          state          <= S_READ;
          pio_chipselect <= 1'b1;
`else
          pio_chipselect <= 1'b0;
          hold_cnt       <= HOLD_LOAD;
          state          <= (HOLD_CYCLES == 0) ? S_IDLE : S_HOLD;
`endif
        end
        S_READ: begin
          pio_chipselect <= 1'b0;
          pio_write_n    <= 1'b1;
          hold_cnt       <= HOLD_LOAD;
          state          <= (HOLD_CYCLES == 0) ? S_IDLE : S_HOLD;
        end
        S_HOLD: begin
          if (hold_cnt == '0) begin
            state <= S_IDLE;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BUSOUT_READBACK_EN
  logic unused_rd_hi;
  assign unused_rd_hi = ^pio_readdata[31:8];

  // Sticky readback error; a mismatch in the same cycle wins over err_clr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else if (state == S_READ && pio_readdata[7:0] != pio_writedata[7:0]) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end
`else
  logic unused_rb;
  assign unused_rb = ^{pio_readdata, err_clr};
  assign err       = 1'b0;
`endif

endmodule
